// File: rtl/calc_pkg.sv
// Shared state codes, key indices and event encoding for the keypad sequencing
// controller of the single-digit BCD calculator.
package calc_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GOT_A  = 3'd1,
    GOT_OP = 3'd2,
    GOT_B  = 3'd3,
    SHOW   = 3'd4
  } state_t;

  // For EVT_OP the event code carries the operation: 0 = add, 1 = subtract.
  typedef enum logic [1:0] {
    EVT_DIGIT = 2'd0,
    EVT_OP    = 2'd1,
    EVT_EQUAL = 2'd2,
    EVT_CLEAR = 2'd3
  } evt_kind_t;

  localparam int unsigned KEY_CLEAR      = 13;
  localparam int unsigned KEY_EQUAL      = 12;
  localparam int unsigned KEY_SUB        = 11;
  localparam int unsigned KEY_ADD        = 10;
  localparam int unsigned NUM_KEYS       = 14;
  localparam int unsigned DEB_CYCLES_DEF = 4;

  function automatic logic [3:0] key_count(input logic [NUM_KEYS-1:0] v);
    logic [3:0] n;
    n = '0;
    for (int unsigned i = 0; i < NUM_KEYS; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/key_debounce_v.sv
// Two-flop synchroniser, stability counter and one-shot event decoder for the
// 14-bit key vector; emits one event (or one error) per accepted press.
module key_debounce_v
  import calc_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] raw_keys,
  output logic                evt_valid,
  output logic [3:0]          evt_code,
  output logic [1:0]          evt_kind,
  output logic                evt_err
);

  localparam logic [7:0] STABLE_MAX = 8'(DEB_CYCLES - 1);

  logic [NUM_KEYS-1:0] sync1, sync2;
  logic [7:0]          cnt;
  logic                armed;
  logic                stable;
  logic [3:0]          n_set;
  logic [3:0]          hot_idx;

  always_comb begin
    stable  = (cnt == STABLE_MAX);
    n_set   = key_count(sync2);
    hot_idx = '0;
    for (int unsigned i = 0; i < NUM_KEYS; i++)
      if (sync2[i]) hot_idx = 4'(i);
  end

  // cnt saturates once sync2 has been held for DEB_CYCLES edges, so an armed
  // debouncer fires exactly once per stable non-zero vector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1     <= '0;
      sync2     <= '0;
      cnt       <= '0;
      armed     <= 1'b0;
      evt_valid <= 1'b0;
      evt_code  <= '0;
      evt_kind  <= '0;
      evt_err   <= 1'b0;
    end else begin
      sync1     <= raw_keys;
      sync2     <= sync1;
      evt_valid <= 1'b0;
      evt_err   <= 1'b0;
      if (sync1 != sync2)
        cnt <= '0;
      else if (!stable)
        cnt <= cnt + 8'd1;

      if (stable) begin
        if (sync2 == '0) begin
          armed <= 1'b1;
        end else if (armed) begin
          armed <= 1'b0;
          if (sync2[KEY_CLEAR]) begin
            evt_valid <= 1'b1;
            evt_kind  <= EVT_CLEAR;
            evt_code  <= '0;
          end else if (n_set == 4'd1) begin
            evt_valid <= 1'b1;
            if (hot_idx < 4'd10) begin
              evt_kind <= EVT_DIGIT;
              evt_code <= hot_idx;
            end else if (hot_idx == 4'(KEY_EQUAL)) begin
              evt_kind <= EVT_EQUAL;
              evt_code <= '0;
            end else begin
              evt_kind <= EVT_OP;
              evt_code <= (hot_idx == 4'(KEY_SUB)) ? 4'd1 : 4'd0;
            end
          end else begin
            evt_err <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/calc_seq_ctrl_v.sv
// Entry state machine for the BCD add/subtract calculator: turns debounced key
// events into registered load/clear strobes, digit code and operation select.
module calc_seq_ctrl_v
  import calc_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [9:0] DIGn,
  input  logic       OP_ADD,
  input  logic       OP_SUB,
  input  logic       EQUAL,
  input  logic       CLEAR,
  output logic [3:0] DIGIT,
  output logic       LD_A,
  output logic       LD_B,
  output logic       LD_R,
  output logic       CLR,
  output logic       ADDN_SUB,
  output logic [2:0] STATE,
  output logic       ERR
);

  state_t              state;
  logic [NUM_KEYS-1:0] raw_keys;
  logic                evt_valid;
  logic [3:0]          evt_code;
  logic [1:0]          evt_kind;
  logic                evt_err;

  assign raw_keys = {CLEAR, EQUAL, OP_SUB, OP_ADD, ~DIGn};
  assign STATE    = state;

  key_debounce_v #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
    .clk      (CLK),
    .rst      (RST),
    .raw_keys (raw_keys),
    .evt_valid(evt_valid),
    .evt_code (evt_code),
    .evt_kind (evt_kind),
    .evt_err  (evt_err)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      DIGIT    <= '0;
      LD_A     <= 1'b0;
      LD_B     <= 1'b0;
      LD_R     <= 1'b0;
      CLR      <= 1'b0;
      ADDN_SUB <= 1'b0;
      ERR      <= 1'b0;
    end else begin
      LD_A <= 1'b0;
      LD_B <= 1'b0;
      LD_R <= 1'b0;
      CLR  <= 1'b0;
      ERR  <= evt_err;
      if (evt_valid) begin
        if (evt_kind == EVT_CLEAR) begin
          CLR      <= 1'b1;
          ADDN_SUB <= 1'b0;
          state    <= IDLE;
        end else begin
          case (state)
            IDLE: begin
              if (evt_kind == EVT_DIGIT) begin
                DIGIT <= evt_code;
                LD_A  <= 1'b1;
                state <= GOT_A;
              end
            end
            GOT_A: begin
              if (evt_kind == EVT_DIGIT) begin
                DIGIT <= evt_code;
                LD_A  <= 1'b1;
              end else if (evt_kind == EVT_OP) begin
                ADDN_SUB <= evt_code[0];
                state    <= GOT_OP;
              end
            end
            GOT_OP: begin
              if (evt_kind == EVT_DIGIT) begin
                DIGIT <= evt_code;
                LD_B  <= 1'b1;
                state <= GOT_B;
              end else if (evt_kind == EVT_OP) begin
                ADDN_SUB <= evt_code[0];
              end
            end
            GOT_B: begin
              if (evt_kind == EVT_DIGIT) begin
                DIGIT <= evt_code;
                LD_B  <= 1'b1;
              end else if (evt_kind == EVT_OP) begin
                ADDN_SUB <= evt_code[0];
              end else if (evt_kind == EVT_EQUAL) begin
                LD_R  <= 1'b1;
                state <= SHOW;
              end
            end
            SHOW: begin
              // A new digit starts a fresh calculation; the datapath applies
              // CLR before the coincident LD_A.
              if (evt_kind == EVT_EQUAL) begin
                LD_R <= 1'b1;
              end else if (evt_kind == EVT_DIGIT) begin
                DIGIT <= evt_code;
                CLR   <= 1'b1;
                LD_A  <= 1'b1;
                state <= GOT_A;
              end
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_calc_seq_ctrl_v.sv
// Self-checking bench for calc_seq_ctrl_v: fixed press table, bounce and
// mid-operation reset sequences, then random presses against a press-level model.
module tb_calc_seq_ctrl_v;

  localparam int DEB = 4;
  localparam int L   = DEB + 3;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [9:0] DIGn = '1;
  logic       OP_ADD = 1'b0, OP_SUB = 1'b0, EQUAL = 1'b0, CLEAR = 1'b0;
  logic [3:0] DIGIT;
  logic       LD_A, LD_B, LD_R, CLR, ADDN_SUB, ERR;
  logic [2:0] STATE;

  calc_seq_ctrl_v #(.DEB_CYCLES(DEB)) dut (
    .CLK(CLK), .RST(RST), .DIGn(DIGn), .OP_ADD(OP_ADD), .OP_SUB(OP_SUB),
    .EQUAL(EQUAL), .CLEAR(CLEAR), .DIGIT(DIGIT), .LD_A(LD_A), .LD_B(LD_B),
    .LD_R(LD_R), .CLR(CLR), .ADDN_SUB(ADDN_SUB), .STATE(STATE), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [3:0] digit;
    logic       lda, ldb, ldr, clr, sub;
    logic [2:0] state;
    logic       err;
  } obs_t;

  typedef struct {
    logic [13:0] keys;
    int          hold;
    obs_t        exp;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  // Press-level model: state as a plain number 0..4, last digit, op select.
  int         m_state = 0;
  logic [3:0] m_digit = '0;
  logic       m_sub   = 1'b0;

  localparam logic [13:0] K_ADD = 14'h0400;
  localparam logic [13:0] K_SUB = 14'h0800;
  localparam logic [13:0] K_EQ  = 14'h1000;
  localparam logic [13:0] K_CLR = 14'h2000;

  function automatic logic [13:0] kd(input int d);
    logic [13:0] one;
    one = 14'd1;
    return one << d;
  endfunction

  function automatic obs_t mk(input int d, input logic a, input logic b, input logic r,
                              input logic c, input logic s, input int st, input logic e);
    obs_t o;
    o.digit = 4'(d); o.lda = a; o.ldb = b; o.ldr = r; o.clr = c; o.sub = s;
    o.state = 3'(st); o.err = e;
    return o;
  endfunction

  function automatic obs_t observe();
    obs_t o;
    o.digit = DIGIT; o.lda = LD_A; o.ldb = LD_B; o.ldr = LD_R; o.clr = CLR;
    o.sub = ADDN_SUB; o.state = STATE; o.err = ERR;
    return o;
  endfunction

  function automatic obs_t model_now();
    return mk(int'(m_digit), 0, 0, 0, 0, m_sub, m_state, 0);
  endfunction

  function automatic obs_t model_press(input logic [13:0] v);
    obs_t e;
    int k;
    e = '0;
    k = -1;
    for (int i = 0; i < 14; i++) if (v[i]) k = i;
    if (v[13]) begin
      e.clr = 1'b1; m_sub = 1'b0; m_state = 0;
    end else if ($countones(v) != 1) begin
      e.err = 1'b1;
    end else if (k < 10) begin
      m_digit = 4'(k);
      if (m_state <= 1)      begin e.lda = 1'b1; m_state = 1; end
      else if (m_state <= 3) begin e.ldb = 1'b1; m_state = 3; end
      else                   begin e.clr = 1'b1; e.lda = 1'b1; m_state = 1; end
    end else if (k == 12) begin
      if (m_state >= 3) begin e.ldr = 1'b1; m_state = 4; end
    end else if (m_state >= 1 && m_state <= 3) begin
      m_sub = (k == 11);
      if (m_state == 1) m_state = 2;
    end
    e.digit = m_digit; e.sub = m_sub; e.state = 3'(m_state);
    return e;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic [13:0] v);
    DIGn   = ~v[9:0];
    OP_ADD = v[10];
    OP_SUB = v[11];
    EQUAL  = v[12];
    CLEAR  = v[13];
  endtask

  function automatic logic pulses();
    return LD_A | LD_B | LD_R | CLR | ERR;
  endfunction

  task automatic check(input string name, input obs_t got, input obs_t exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got digit=%0d ldA=%b ldB=%b ldR=%b clr=%b sub=%b state=%0d err=%b, expected digit=%0d ldA=%b ldB=%b ldR=%b clr=%b sub=%b state=%0d err=%b",
               name, got.digit, got.lda, got.ldb, got.ldr, got.clr, got.sub, got.state, got.err,
               exp.digit, exp.lda, exp.ldb, exp.ldr, exp.clr, exp.sub, exp.state, exp.err);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Press, check outputs exactly at edge L, and count any strobe outside it.
  task automatic do_press(input string name, input logic [13:0] v, input int hold, input obs_t exp);
    int stray;
    stray = 0;
    drive(v);
    for (int i = 1; i < L; i++) begin tick(); if (pulses()) stray++; end
    tick();
    check(name, observe(), exp);
    for (int i = L + 1; i <= hold; i++) begin tick(); if (pulses()) stray++; end
    drive('0);
    for (int i = 0; i < DEB + 6; i++) begin tick(); if (pulses()) stray++; end
    check_int({name, " stray pulses"}, stray, 0);
  endtask

  vec_t tbl[11];

  initial begin
    int stray;
    obs_t e;
    logic [13:0] v;
    int r, a, b;

    tbl[0]  = '{kd(3), 20, mk(3, 1, 0, 0, 0, 0, 1, 0)};
    tbl[1]  = '{kd(7), 8,  mk(7, 1, 0, 0, 0, 0, 1, 0)};
    tbl[2]  = '{K_SUB, 8,  mk(7, 0, 0, 0, 0, 1, 2, 0)};
    tbl[3]  = '{kd(9), 8,  mk(9, 0, 1, 0, 0, 1, 3, 0)};
    tbl[4]  = '{K_EQ,  8,  mk(9, 0, 0, 1, 0, 1, 4, 0)};
    tbl[5]  = '{K_EQ,  9,  mk(9, 0, 0, 1, 0, 1, 4, 0)};
    tbl[6]  = '{kd(2), 8,  mk(2, 1, 0, 0, 1, 1, 1, 0)};
    tbl[7]  = '{kd(4) | kd(5), 8, mk(2, 0, 0, 0, 0, 1, 1, 1)};
    tbl[8]  = '{K_CLR | kd(5), 8, mk(2, 0, 0, 0, 1, 0, 0, 0)};
    tbl[9]  = '{K_ADD, 8,  mk(2, 0, 0, 0, 0, 0, 0, 0)};
    tbl[10] = '{K_EQ,  8,  mk(2, 0, 0, 0, 0, 0, 0, 0)};

    drive('0);
    repeat (3) tick();
    check("reset values", observe(), '0);
    RST = 1'b0;
    repeat (DEB + 6) tick();
    check("idle after reset", observe(), '0);

    foreach (tbl[i]) begin
      e = model_press(tbl[i].keys);
      do_press($sformatf("table[%0d]", i), tbl[i].keys, tbl[i].hold, tbl[i].exp);
    end

    // Bounce: 2-cycle low pulses on digit 6 while in GOT_A.
    do_press("bounce setup", kd(1), 8, model_press(kd(1)));
    stray = 0;
    for (int i = 0; i < 5; i++) begin
      drive(kd(6)); tick(); if (pulses()) stray++; tick(); if (pulses()) stray++;
      drive('0);    tick(); if (pulses()) stray++; tick(); if (pulses()) stray++;
    end
    for (int i = 0; i < DEB + 6; i++) begin tick(); if (pulses()) stray++; end
    check_int("bounce pulses", stray, 0);
    check("bounce state", observe(), model_now());

    // Reset in GOT_B with a key held.
    do_press("to GOT_OP", K_ADD, 8, model_press(K_ADD));
    do_press("to GOT_B", kd(8), 8, model_press(kd(8)));
    drive(kd(5));
    tick(); tick();
    #3 RST = 1'b1;
    #1 check("async reset mid-op", observe(), '0);
    m_state = 0; m_digit = '0; m_sub = 1'b0;
    tick(); tick();
    RST = 1'b0;
    stray = 0;
    for (int i = 0; i < 20; i++) begin tick(); if (pulses()) stray++; end
    check_int("held through reset pulses", stray, 0);
    check("held through reset state", observe(), '0);
    drive('0);
    repeat (DEB + 6) tick();
    do_press("press after reset", kd(4), 8, model_press(kd(4)));

    for (int n = 0; n < 40; n++) begin
      r = int'($urandom_range(0, 17));
      if (r < 10)       v = kd(r);
      else if (r == 10) v = K_ADD;
      else if (r == 11) v = K_SUB;
      else if (r <= 13) v = K_EQ;
      else if (r == 14) v = K_CLR;
      else if (r == 15) begin
        a = int'($urandom_range(0, 12));
        b = (a + 1 + int'($urandom_range(0, 11))) % 13;
        v = kd(a) | kd(b);
      end else if (r == 16) v = K_CLR | kd(int'($urandom_range(0, 12)));
      else v = kd(int'($urandom_range(0, 9)));
      e = model_press(v);
      do_press($sformatf("random[%0d] keys=%h", n, v), v, L + int'($urandom_range(0, 6)), e);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/calc_seq_ctrl_v.md
# calc_seq_ctrl_v

Keypad sequencing controller for the single-digit BCD add/subtract calculator. It synchronises and debounces the ten digit keys and the ADD, SUB, EQUAL and CLEAR buttons, then runs the entry state machine. It drives the load strobes, digit code and add/subtract select for the operand/result register datapath (74174 registers, 74147 encoder, 74283 adder). It replaces the free-running clicked-key clocks with clean single-cycle enables in one clock domain.

## Interface
- DEB_CYCLES, 4: cycles a key vector must be stable before a press or release is accepted; legal range 2..255.
- CLK  in  1  system clock, rising edge.
- RST  in  1  reset; asynchronous, active-high.
- DIGn  in  10  digit keys 0..9; active-low; idle high; asynchronous to CLK.
- OP_ADD  in  1  add button; active-high; asynchronous.
- OP_SUB  in  1  subtract button; active-high; asynchronous.
- EQUAL  in  1  equals button; active-high; asynchronous.
- CLEAR  in  1  clear button; active-high; asynchronous.
- DIGIT  out  4  binary code of the last accepted digit; held between presses.
- LD_A  out  1  one-cycle load-enable pulse for the operand A register.
- LD_B  out  1  one-cycle load-enable pulse for the operand B register.
- LD_R  out  1  one-cycle load-enable pulse for the result register.
- CLR  out  1  one-cycle pulse that clears the A, B and R registers.
- ADDN_SUB  out  1  operation select: 0 = add, 1 = subtract; level output.
- STATE  out  3  current FSM state code.
- ERR  out  1  one-cycle pulse when a press is rejected.

## Operation
**Key vector**
- The raw key vector is the 14-bit value {CLEAR, EQUAL, OP_SUB, OP_ADD, ~DIGn[9:0]}.
- It passes through a two-flop synchroniser.

**Debouncer**
- A counter tracks how long the synchronised vector has stayed unchanged.
- A press is accepted once a non-zero vector has been stable for DEB_CYCLES cycles while the debouncer is armed. Exactly one event is produced and the debouncer disarms.
- The debouncer re-arms after an all-zero vector has been stable for DEB_CYCLES cycles.
- A key held down produces only one event.
- Event decode:
  - If CLEAR is set, the event is CLEAR, regardless of any other bits.
  - Otherwise, if exactly one bit is set, the event is that key.
  - Otherwise, no event is produced, ERR pulses, and the debouncer still disarms.

**FSM states**
- IDLE=0, GOT_A=1, GOT_OP=2, GOT_B=3, SHOW=4.

**CLEAR event (any state)**
- CLR pulses, ADDN_SUB goes to 0, and the FSM goes to IDLE.

**Transitions**
- IDLE:
  - digit d: DIGIT=d, LD_A pulses, go to GOT_A.
  - OP_ADD, OP_SUB, EQUAL: ignored.
- GOT_A:
  - digit: reload A (DIGIT=d, LD_A pulses), stay.
  - OP_ADD: ADDN_SUB=0, go to GOT_OP.
  - OP_SUB: ADDN_SUB=1, go to GOT_OP.
  - EQUAL: ignored.
- GOT_OP:
  - OP_ADD or OP_SUB: update ADDN_SUB, stay.
  - digit: DIGIT=d, LD_B pulses, go to GOT_B.
  - EQUAL: ignored.
- GOT_B:
  - digit: reload B, stay.
  - OP_ADD or OP_SUB: update ADDN_SUB, stay.
  - EQUAL: LD_R pulses, go to SHOW.
- SHOW:
  - EQUAL: LD_R pulses again, stay.
  - digit d: CLR and LD_A pulse together with DIGIT=d, go to GOT_A. The datapath applies clear before load.
  - OP_ADD, OP_SUB: ignored.

**Outputs**
- At most one of LD_A, LD_B or LD_R is high in any cycle.
- CLR may coincide only with LD_A, and only on the SHOW-state digit transition.

## Timing
**Reset values**
- All outputs are 0 and STATE=IDLE.
- Synchroniser, counter and armed flag are all cleared to 0.
- A key held through reset release is not accepted until it has been released for DEB_CYCLES cycles.

**Latency**
- Press latency is L = DEB_CYCLES + 3 edges:
  - Count from the first CLK edge at which the new raw vector is sampled.
  - Strobes, DIGIT, ADDN_SUB and STATE all update on edge L.
  - Pulses stay high for exactly one cycle.
- The next press can be accepted no earlier than DEB_CYCLES + 2 edges after the vector returns to all-zero.

**Bounce and reset mid-operation**
- A raw glitch shorter than DEB_CYCLES cycles produces no event and no ERR.
- Asserting RST mid-operation aborts immediately, with no pulse emitted.

## Structure
- Package calc_pkg holds:
  - state codes IDLE..SHOW;
  - key-index constants KEY_CLEAR=13, KEY_EQUAL=12, KEY_SUB=11, KEY_ADD=10;
  - the DEB_CYCLES default.
- Sub-module key_debounce_v contains the synchroniser, stability counter, armed flag, event decode and ERR. It outputs evt_valid, evt_code[3:0] and evt_kind[1:0].
- calc_seq_ctrl_v contains the FSM and output registers.

## Test plan
All scenarios use DEB_CYCLES=4, so L=7.
- Reset, then press digit 3 held for 20 cycles: DIGIT=3 and LD_A pulses once at edge 7; STATE=1; no further pulses while held.
- Sequence 7, SUB, 9, EQUAL, each key released ≥6 cycles between presses: pulses in order LD_A (DIGIT=7), LD_B (DIGIT=9), LD_R; ADDN_SUB=1; final STATE=4.
- From SHOW, press EQUAL, then digit 2: second LD_R pulse; then CLR and LD_A pulse in the same cycle with DIGIT=2; STATE=1.
- Press digits 4 and 5 simultaneously: ERR pulses once; no load strobe; STATE unchanged. CLEAR pressed together with digit 5: CLR pulses; STATE=0.
- Digit key bouncing with 2-cycle low pulses: no event. Assert RST in GOT_B while a key is held: all outputs 0 at once; no event until the key is released.
